// File: rtl/sd_host_cmd.sv
// sd_host_cmd: SD-bus host command engine.
// Generates sdclk from clk, serialises one 48-bit command on CMD (drive on sdclk
// fall, sample on sdclk rise), then captures a 48-bit or 136-bit response.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 transaction request, accepted only when idle
//   cmd_idx, cmd_arg      command index/argument, latched on accept
//   resp_type             0 none, 1 48-bit CRC checked, 2 136-bit, 3 48-bit CRC ignored
//   busy, done            busy from accept to done; done is a one-clk pulse
//   timeout, crc_err      status, valid with done, held until next accept
//   resp_idx, resp_arg    received index field and payload
//   sdclk                 SD clock, free-running
//   sdcmdoe, sdcmdout     CMD line output enable / data
//   sdcmdin               CMD line input (already synchronised)
//
// Configuration macro: SDCMD_RESP_CRC_CHK_EN
//   defined   -> response CRC7 is computed and compared (types 1 and 2)
//   undefined -> no response CRC logic, crc_err flags end-bit errors only
module sd_host_cmd #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned NCC          = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [5:0]   cmd_idx,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic [5:0]   resp_idx,
  output logic [119:0] resp_arg,
  output logic         sdclk,
  output logic         sdcmdoe,
  output logic         sdcmdout,
  input  logic         sdcmdin
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned CNT_MAX = (RESP_TIMEOUT > NCC)
                                    ? ((RESP_TIMEOUT > 136) ? RESP_TIMEOUT : 136)
                                    : ((NCC > 136) ? NCC : 136);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SR_W    = 126;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TX   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_NCC  = 3'd4;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  logic [DIV_W-1:0] div_q;
  logic             sdclk_q;
  logic             tick_c, rise_c, fall_c;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [6:0]       crc_q, crc_d;
  logic [1:0]       rtype_q, rtype_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             crc_err_q, crc_err_d;
  logic [5:0]       resp_idx_q, resp_idx_d;
  logic [119:0]     resp_arg_q, resp_arg_d;
  logic             oe_q, oe_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] last_pos_c, crc_pos_c;
`ifdef SDCMD_RESP_CRC_CHK_EN
  logic [6:0]       rx_crc_q, rx_crc_d;
`endif

  // sdclk divider: toggle every CLK_DIV clk, strobes mark the edge being made
  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_c = tick_c & ~sdclk_q;
  assign fall_c = tick_c &  sdclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      sdclk_q <= 1'b0;
    end else if (tick_c) begin
      div_q   <= '0;
      sdclk_q <= ~sdclk_q;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  // Response frame positions: CRC bits start at crc_pos, end bit at last_pos
  assign last_pos_c = (rtype_q == 2'd2) ? CNT_W'(135) : CNT_W'(47);
  assign crc_pos_c  = last_pos_c - CNT_W'(7);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    crc_d      = crc_q;
    rtype_d    = rtype_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    crc_err_d  = crc_err_q;
    resp_idx_d = resp_idx_q;
    resp_arg_d = resp_arg_q;
    oe_d       = oe_q;
    out_d      = out_q;
`ifdef SDCMD_RESP_CRC_CHK_EN
    rx_crc_d   = rx_crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d       = {86'd0, 2'b01, cmd_idx, cmd_arg};
          rtype_d    = resp_type;
          crc_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          timeout_d  = 1'b0;
          crc_err_d  = 1'b0;
          resp_idx_d = '0;
          resp_arg_d = '0;
          state_d    = S_TX;
        end
      end
      S_TX: begin
        if (fall_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          oe_d  = 1'b1;
          if (cnt_q < CNT_W'(40)) begin
            out_d = sr_q[39];
            crc_d = crc7_next(crc_q, sr_q[39]);
            sr_d  = {sr_q[SR_W-2:0], 1'b0};
          end else if (cnt_q < CNT_W'(47)) begin
            out_d = crc_q[6];
            crc_d = {crc_q[5:0], 1'b0};
          end else if (cnt_q == CNT_W'(47)) begin
            out_d = 1'b1;
          end else begin
            // end bit's period is over: release the line
            oe_d    = 1'b0;
            out_d   = 1'b1;
            cnt_d   = '0;
            crc_d   = '0;
            state_d = (rtype_q == 2'd0) ? S_NCC : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // start bit is checked before expiry so it wins on the last rise
        if (rise_c) begin
          if (!sdcmdin) begin
            cnt_d   = CNT_W'(1);
            crc_d   = '0;
            state_d = S_RX;
          end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_NCC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RX: begin
        if (rise_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q < crc_pos_c) begin
            // start and transmission bits are not stored
            if (cnt_q >= CNT_W'(2)) sr_d = {sr_q[SR_W-2:0], sdcmdin};
`ifdef SDCMD_RESP_CRC_CHK_EN
            crc_d = crc7_next(crc_q, sdcmdin);
`endif
          end else if (cnt_q < last_pos_c) begin
`ifdef SDCMD_RESP_CRC_CHK_EN
            rx_crc_d = {rx_crc_q[5:0], sdcmdin};
`endif
          end else begin
            crc_err_d = ~sdcmdin;
`ifdef SDCMD_RESP_CRC_CHK_EN
            if ((rtype_q != 2'd3) && (rx_crc_q != crc_q)) crc_err_d = 1'b1;
`endif
            resp_idx_d = (rtype_q == 2'd2) ? sr_q[125:120] : sr_q[37:32];
            resp_arg_d = (rtype_q == 2'd2) ? sr_q[119:0] : {88'd0, sr_q[31:0]};
            cnt_d      = '0;
            state_d    = S_NCC;
          end
        end
      end
      S_NCC: begin
        oe_d  = 1'b0;
        out_d = 1'b1;
        if (rise_c) begin
          if (cnt_q == CNT_W'(NCC - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
        out_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      crc_q      <= '0;
      rtype_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      resp_idx_q <= '0;
      resp_arg_q <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
`ifdef SDCMD_RESP_CRC_CHK_EN
      rx_crc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      crc_q      <= crc_d;
      rtype_q    <= rtype_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      crc_err_q  <= crc_err_d;
      resp_idx_q <= resp_idx_d;
      resp_arg_q <= resp_arg_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
`ifdef SDCMD_RESP_CRC_CHK_EN
      rx_crc_q   <= rx_crc_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign crc_err  = crc_err_q;
  assign resp_idx = resp_idx_q;
  assign resp_arg = resp_arg_q;
  assign sdclk    = sdclk_q;
  assign sdcmdoe  = oe_q;
  assign sdcmdout = out_q;

endmodule
